// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV32I/RV64I immediate generator with 2-entry skid buffer (optional CSR zimm: IMM_GEN_PIPE_CSR_EN)
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_PIPE_CSR_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  logic [31:0]      imm32;
  logic [2:0]       dec_fmt;
  logic [XLEN-1:0]  dec_imm;

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [2:0]       main_fmt_q,   main_fmt_d;
  logic [XLEN-1:0]  main_pc_q,    main_pc_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [2:0]       skid_fmt_q,   skid_fmt_d;
  logic [XLEN-1:0]  skid_pc_q,    skid_pc_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  logic             accept;
  logic             drain;

  // Opcode decode: build a 32-bit sign-correct immediate, then widen to XLEN.
  // zimm has bit 31 clear, so the common sign-extension also zero-extends it.
  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_NONE;
    case (in_inst[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          dec_fmt = FMT_I;
          imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {in_inst[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
`ifdef IMM_GEN_PIPE_CSR_EN
      7'b1110011: begin
        if (in_inst[14] && (in_inst[13:12] != 2'b00)) begin
          dec_fmt = FMT_Z;
          imm32   = {27'b0, in_inst[19:15]};
        end
      end
`endif
      default: begin
        imm32   = '0;
        dec_fmt = FMT_NONE;
      end
    endcase
    dec_imm = XLEN'($signed(imm32));
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && !skid_valid_q;
  assign drain    = main_valid_q && out_ready;

  // Main/skid next state: flush wins, then drain refills main from skid or input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_pc_d    = main_pc_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_pc_d    = skid_pc_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      if (skid_valid_q) begin
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        main_pc_d    = skid_pc_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_imm_d   = dec_imm;
        main_fmt_d   = dec_fmt;
        main_pc_d    = in_pc;
        main_tag_d   = in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm;
        skid_fmt_d   = dec_fmt;
        skid_pc_d    = in_pc;
        skid_tag_d   = in_tag;
      end else begin
        main_valid_d = 1'b1;
        main_imm_d   = dec_imm;
        main_fmt_d   = dec_fmt;
        main_pc_d    = in_pc;
        main_tag_d   = in_tag;
      end
    end
  end

  // State registers; reset clears valids and zeroes all data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= '0;
      main_pc_q    <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_pc_q    <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_pc_q    <= main_pc_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_pc_q    <= skid_pc_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_imm   = main_imm_q;
  assign out_fmt   = main_fmt_q;
  assign out_pc    = main_pc_q;
  assign out_tag   = main_tag_q;

endmodule
